// File: rtl/lc3_fetch_unit_if.sv
// Instruction-memory port of the LC-3 fetch stage: read request out,
// instruction word and completion strobe back.
interface lc3_fetch_unit_if;
   logic        instrmem_rd;
   logic [15:0] Instr_dout;
   logic        complete_instr;

   modport master (
      output instrmem_rd,
      input  Instr_dout,
      input  complete_instr
   );

   modport slave (
      input  instrmem_rd,
      output Instr_dout,
      output complete_instr
   );
endinterface

// File: rtl/lc3_fetch_unit.sv
// LC-3 fetch stage: PC/NPC, single outstanding instruction read, redirect squash.
// Define LC3_FETCH_TIMEOUT_EN to add the WAIT watchdog and the sticky fetch_err output.
module lc3_fetch_unit #(
   parameter logic [15:0] BASE_ADDR      = 16'h3000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable_fetch,
   input  logic                enable_updatePC,
   input  logic                br_taken,
   input  logic [15:0]         taddr,
   lc3_fetch_unit_if.master    mem,
   output logic [15:0]         pc,
   output logic [15:0]         npc,
   output logic [15:0]         instr,
   output logic [15:0]         instr_pc,
   output logic                instr_valid,
`ifdef LC3_FETCH_TIMEOUT_EN
   output logic                fetch_err,
`endif
   output logic                fetch_stall
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] req_pc_q, req_pc_d;
   logic        squash_q, squash_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
`ifdef LC3_FETCH_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        err_q, err_d;
`endif

   assign npc         = pc_q + 16'h0001;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign mem.instrmem_rd = enable_fetch & ~reset;
   assign fetch_stall = (state_q == S_WAIT) & ~mem.complete_instr;
`ifdef LC3_FETCH_TIMEOUT_EN
   assign fetch_err   = err_q;
`endif

   // PC advance / redirect
   always_comb begin
      pc_d = pc_q;
      if (enable_updatePC) begin
         pc_d = br_taken ? taddr : npc;
      end else begin
         pc_d = pc_q;
      end
   end

   // Fetch FSM: request tracking, squash and response capture
   always_comb begin
      state_d       = state_q;
      req_pc_d      = req_pc_q;
      squash_d      = squash_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
`ifdef LC3_FETCH_TIMEOUT_EN
      wait_cnt_d    = wait_cnt_q;
      err_d         = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (enable_fetch) begin
               state_d  = S_WAIT;
               req_pc_d = pc_q;
               squash_d = 1'b0;
`ifdef LC3_FETCH_TIMEOUT_EN
               wait_cnt_d = 8'd0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (mem.complete_instr) begin
               if (!squash_q) begin
                  instr_d       = mem.Instr_dout;
                  instr_pc_d    = req_pc_q;
                  instr_valid_d = 1'b1;
               end else begin
                  instr_valid_d = 1'b0;
               end
               // A new request in the response cycle keeps the FSM in WAIT
               if (enable_fetch) begin
                  req_pc_d = pc_q;
                  squash_d = 1'b0;
`ifdef LC3_FETCH_TIMEOUT_EN
                  wait_cnt_d = 8'd0;
`endif
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               if (enable_updatePC && br_taken) begin
                  squash_d = 1'b1;
               end else begin
                  squash_d = squash_q;
               end
`ifdef LC3_FETCH_TIMEOUT_EN
               if (wait_cnt_q == WAIT_LAST) begin
                  err_d    = 1'b1;
                  state_d  = S_IDLE;
                  squash_d = 1'b0;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pc_q          <= BASE_ADDR;
         req_pc_q      <= 16'h0000;
         squash_q      <= 1'b0;
         instr_q       <= 16'h0000;
         instr_pc_q    <= 16'h0000;
         instr_valid_q <= 1'b0;
`ifdef LC3_FETCH_TIMEOUT_EN
         wait_cnt_q    <= 8'd0;
         err_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         req_pc_q      <= req_pc_d;
         squash_q      <= squash_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
`ifdef LC3_FETCH_TIMEOUT_EN
         wait_cnt_q    <= wait_cnt_d;
         err_q         <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Self-checking bench for lc3_fetch_unit: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_lc3_fetch_unit;
   localparam logic [15:0] BASE = 16'h3000;
   localparam int          TMO  = 4;

   logic        clk = 1'b0;
   logic        reset, enable_fetch, enable_updatePC, br_taken;
   logic [15:0] taddr, pc, npc, instr, instr_pc;
   logic        instr_valid, fetch_stall;
`ifdef LC3_FETCH_TIMEOUT_EN
   logic        fetch_err;
`endif

   lc3_fetch_unit_if mem_if ();

   lc3_fetch_unit #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
      .clk             (clk),
      .reset           (reset),
      .enable_fetch    (enable_fetch),
      .enable_updatePC (enable_updatePC),
      .br_taken        (br_taken),
      .taddr           (taddr),
      .mem             (mem_if.master),
      .pc              (pc),
      .npc             (npc),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_valid     (instr_valid),
`ifdef LC3_FETCH_TIMEOUT_EN
      .fetch_err       (fetch_err),
`endif
      .fetch_stall     (fetch_stall)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: architectural view of the fetch stage
   logic [15:0] m_pc = BASE, m_req = 16'h0000, m_instr = 16'h0000, m_ipc = 16'h0000;
   logic        m_busy = 1'b0, m_squash = 1'b0, m_valid = 1'b0, m_err = 1'b0;
   int          m_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [15:0] next_pc;
      if (reset) begin
         m_pc = BASE; m_busy = 1'b0; m_squash = 1'b0; m_instr = 16'h0000;
         m_ipc = 16'h0000; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
         return;
      end
      next_pc = enable_updatePC ? (br_taken ? taddr : m_pc + 16'h0001) : m_pc;
      m_valid = 1'b0;
      if (!m_busy) begin
         if (enable_fetch) begin
            m_busy = 1'b1; m_req = m_pc; m_squash = 1'b0; m_cnt = 0;
         end
      end else if (mem_if.complete_instr) begin
         if (!m_squash) begin
            m_instr = mem_if.Instr_dout; m_ipc = m_req; m_valid = 1'b1;
         end
         if (enable_fetch) begin
            m_req = m_pc; m_squash = 1'b0; m_cnt = 0;
         end else begin
            m_busy = 1'b0;
         end
      end else begin
         if (enable_updatePC && br_taken) m_squash = 1'b1;
`ifdef LC3_FETCH_TIMEOUT_EN
         m_cnt++;
         if (m_cnt == TMO) begin
            m_err = 1'b1; m_busy = 1'b0; m_squash = 1'b0;
         end
`endif
      end
      m_pc = next_pc;
   endtask

   // One clock: combinational checks mid-cycle, registered checks after the edge
   task automatic cycle();
      @(negedge clk);
      check_val("instrmem_rd", {31'd0, mem_if.instrmem_rd}, {31'd0, enable_fetch & ~reset});
      if (!reset) begin
         check_val("npc", {16'd0, npc}, {16'd0, m_pc + 16'h0001});
         check_val("fetch_stall", {31'd0, fetch_stall}, {31'd0, m_busy & ~mem_if.complete_instr});
      end
      @(posedge clk);
      model_edge();
      #1;
      check_val("pc", {16'd0, pc}, {16'd0, m_pc});
      check_val("instr", {16'd0, instr}, {16'd0, m_instr});
      check_val("instr_pc", {16'd0, instr_pc}, {16'd0, m_ipc});
      check_val("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
`ifdef LC3_FETCH_TIMEOUT_EN
      check_val("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
`endif
   endtask

   task automatic drive(input logic ef, input logic upd, input logic br,
                        input logic [15:0] ta, input logic ci, input logic [15:0] dout);
      enable_fetch = ef; enable_updatePC = upd; br_taken = br; taddr = ta;
      mem_if.complete_instr = ci; mem_if.Instr_dout = dout;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      do_reset();
      check_val("rst_pc", {16'd0, pc}, {16'd0, BASE});
      check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
      check_val("rst_instr", {16'd0, instr}, 32'd0);

      // Sequential fetch with 1-cycle responses
      for (int i = 0; i < 4; i++) begin
         check_val("seq_pc", {16'd0, pc}, {16'd0, BASE + 16'(i)});
         drive(1'b1, 1'b1, 1'b0, 16'h0000, m_busy, 16'(16'h5000 + i));
         cycle();
      end

      // Slow response: three stall cycles, then one valid pulse
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
         #1 check_val("slow_stall", {31'd0, fetch_stall}, 32'd1);
         cycle();
      end
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1261);
      cycle();
      check_val("slow_instr", {16'd0, instr}, 32'h1261);
      check_val("slow_ipc", {16'd0, instr_pc}, 32'h3000);
      check_val("slow_valid", {31'd0, instr_valid}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      cycle();
      check_val("slow_once", {31'd0, instr_valid}, 32'd0);

      // Redirect during WAIT squashes the pending response
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      cycle();
      drive(1'b0, 1'b1, 1'b1, 16'h3040, 1'b0, 16'h0000);
      cycle();
      check_val("redir_pc", {16'd0, pc}, 32'h3040);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0FFF);
      cycle();
      check_val("squash_valid", {31'd0, instr_valid}, 32'd0);
      check_val("squash_instr", {16'd0, instr}, 32'h1261);

      // PC wrap
      drive(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000);
      cycle();
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
      #1 check_val("wrap_npc", {16'd0, npc}, 32'h0000);
      cycle();
      check_val("wrap_pc", {16'd0, pc}, 32'h0000);

`ifdef LC3_FETCH_TIMEOUT_EN
      // Watchdog: no response for TMO WAIT cycles
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      for (int i = 0; i < TMO; i++) cycle();
      check_val("tmo_err", {31'd0, fetch_err}, 32'd1);
      check_val("tmo_idle", {31'd0, fetch_stall}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
      cycle();
      check_val("tmo_late_valid", {31'd0, instr_valid}, 32'd0);
      check_val("tmo_sticky", {31'd0, fetch_err}, 32'd1);
`endif

      // Reset mid-WAIT together with a response
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      cycle();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hABCD);
      cycle();
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      check_val("rstw_valid", {31'd0, instr_valid}, 32'd0);
      check_val("rstw_pc", {16'd0, pc}, 32'h3000);
      check_val("rstw_instr", {16'd0, instr}, 32'h0000);
      check_val("rstw_ipc", {16'd0, instr_pc}, 32'h0000);
      #1 check_val("rstw_stall", {31'd0, fetch_stall}, 32'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 99) < 2);
         drive($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
               $urandom_range(0, 9) < 3, 16'($urandom()),
               $urandom_range(0, 1) == 1, 16'($urandom()));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
